// File: rtl/fsmc_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fsmc_master: multiplexed-AD FSMC bus master (ADDR/AHLD/TURN/DATA/HOLD).  |
// | Optional burst mode via FSMC_MASTER_BURST_EN.   Revision: 1.0            |
// +--------------------------------------------------------------------------+
module fsmc_master #(
  parameter int unsigned ADDSET = 5,
  parameter int unsigned ADDHLD = 4,
  parameter int unsigned DATAST = 10,
  parameter int unsigned HOLD   = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [17:0] req_addr,
  input  logic [15:0] req_wdata,
`ifdef FSMC_MASTER_BURST_EN
  input  logic [10:0] req_len,
`endif
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_last,
  output logic [17:0] ad_out,
  output logic        ad_oe,
  input  logic [17:0] ad_in,
  output logic        nadv,
  output logic        nwe,
  output logic        noe
);

  localparam int unsigned ADDSET_E = (ADDSET == 0) ? 1 : ADDSET;
  localparam int unsigned ADDHLD_E = (ADDHLD == 0) ? 1 : ADDHLD;
  localparam int unsigned DATAST_E = (DATAST == 0) ? 1 : DATAST;
  localparam int unsigned HOLD_E   = (HOLD == 0) ? 1 : HOLD;
  localparam int unsigned MAX_A    = (ADDSET_E > ADDHLD_E) ? ADDSET_E : ADDHLD_E;
  localparam int unsigned MAX_B    = (DATAST_E > HOLD_E) ? DATAST_E : HOLD_E;
  localparam int unsigned MAX_T    = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CNT_W    = (MAX_T > 1) ? $clog2(MAX_T) : 1;

  localparam logic [CNT_W-1:0] ADDSET_LAST = CNT_W'(ADDSET_E - 1);
  localparam logic [CNT_W-1:0] ADDHLD_LAST = CNT_W'(ADDHLD_E - 1);
  localparam logic [CNT_W-1:0] DATAST_LAST = CNT_W'(DATAST_E - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_E - 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_AHLD = 3'd2,
    ST_TURN = 3'd3,
    ST_DATA = 3'd4,
    ST_HOLD = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             write_q, write_d;
  logic [17:0]      addr_q, addr_d;
  logic [15:0]      wdata_q, wdata_d;
  logic [15:0]      rd_cap_q, rd_cap_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_last_q, rsp_last_d;
  logic [15:0]      rsp_rdata_q, rsp_rdata_d;
  logic             nadv_q, nadv_d;
  logic             nwe_q, nwe_d;
  logic             noe_q, noe_d;
  logic             ad_oe_q, ad_oe_d;
  logic [17:0]      ad_out_q, ad_out_d;
  logic             last_word;
  logic             unused_ad_hi;

`ifdef FSMC_MASTER_BURST_EN
  // rem_q counts the words still to run after the current one
  logic [10:0]      rem_q, rem_d;
  assign last_word = (rem_q == 11'd0);
`else
  assign last_word = 1'b1;
`endif

  assign unused_ad_hi = ^ad_in[17:16];
  assign req_ready    = (state_q == ST_IDLE) && !rst;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rd_cap_d    = rd_cap_q;
    rsp_valid_d = 1'b0;
    rsp_last_d  = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
`ifdef FSMC_MASTER_BURST_EN
    rem_d       = rem_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          state_d = ST_ADDR;
          cnt_d   = '0;
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
`ifdef FSMC_MASTER_BURST_EN
          if (req_len == 11'd0) begin
            rem_d = 11'd0;
          end else if (req_len > 11'd1024) begin
            rem_d = 11'd1023;
          end else begin
            rem_d = req_len - 11'd1;
          end
`endif
        end
      end
      ST_ADDR: begin
        if (cnt_q == ADDSET_LAST) begin
          state_d = ST_AHLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_AHLD: begin
        if (cnt_q == ADDHLD_LAST) begin
          state_d = write_q ? ST_DATA : ST_TURN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_TURN: begin
        state_d = ST_DATA;
        cnt_d   = '0;
      end
      ST_DATA: begin
        if (cnt_q == DATAST_LAST) begin
          if (!write_q) begin
            rd_cap_d = ad_in[15:0];
          end
          state_d = ST_HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          rsp_valid_d = 1'b1;
          rsp_last_d  = last_word;
          rsp_rdata_d = write_q ? 16'h0000 : rd_cap_q;
          cnt_d       = '0;
          if (last_word) begin
            state_d = ST_IDLE;
          end else begin
            // next burst word starts immediately, address wraps at 2^18
            state_d = ST_ADDR;
            addr_d  = addr_q + 18'd1;
`ifdef FSMC_MASTER_BURST_EN
            rem_d   = rem_q - 11'd1;
`endif
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // bus pins are registered from the next state so they never glitch
    nadv_d   = 1'b1;
    nwe_d    = 1'b1;
    noe_d    = 1'b1;
    ad_oe_d  = 1'b0;
    ad_out_d = 18'd0;
    case (state_d)
      ST_ADDR: begin
        nadv_d   = 1'b0;
        ad_oe_d  = 1'b1;
        ad_out_d = addr_d;
      end
      ST_AHLD: begin
        ad_oe_d  = 1'b1;
        ad_out_d = addr_d;
      end
      ST_DATA: begin
        if (write_d) begin
          nwe_d    = 1'b0;
          ad_oe_d  = 1'b1;
          ad_out_d = {2'b00, wdata_d};
        end else begin
          noe_d = 1'b0;
        end
      end
      ST_HOLD: begin
        if (write_d) begin
          ad_oe_d  = 1'b1;
          ad_out_d = {2'b00, wdata_d};
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      write_q     <= 1'b0;
      addr_q      <= 18'd0;
      wdata_q     <= 16'h0000;
      rd_cap_q    <= 16'h0000;
      rsp_valid_q <= 1'b0;
      rsp_last_q  <= 1'b0;
      rsp_rdata_q <= 16'h0000;
      nadv_q      <= 1'b1;
      nwe_q       <= 1'b1;
      noe_q       <= 1'b1;
      ad_oe_q     <= 1'b0;
      ad_out_q    <= 18'd0;
`ifdef FSMC_MASTER_BURST_EN
      rem_q       <= 11'd0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rd_cap_q    <= rd_cap_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_last_q  <= rsp_last_d;
      rsp_rdata_q <= rsp_rdata_d;
      nadv_q      <= nadv_d;
      nwe_q       <= nwe_d;
      noe_q       <= noe_d;
      ad_oe_q     <= ad_oe_d;
      ad_out_q    <= ad_out_d;
`ifdef FSMC_MASTER_BURST_EN
      rem_q       <= rem_d;
`endif
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_last  = rsp_last_q;
  assign rsp_rdata = rsp_rdata_q;
  assign nadv      = nadv_q;
  assign nwe       = nwe_q;
  assign noe       = noe_q;
  assign ad_oe     = ad_oe_q;
  assign ad_out    = ad_out_q;

endmodule
`default_nettype wire

// File: tb/tb_fsmc_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fsmc_master: directed self-checking bench for fsmc_master.            |
// | Burst scenarios build only with FSMC_MASTER_BURST_EN.  Revision: 1.0     |
// +--------------------------------------------------------------------------+
module tb_fsmc_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_valid_z, req_write;
  logic [17:0] req_addr;
  logic [15:0] req_wdata;
  logic [17:0] ad_in;
`ifdef FSMC_MASTER_BURST_EN
  logic [10:0] req_len;
`endif
  logic        req_ready, rsp_valid, rsp_last, ad_oe, nadv, nwe, noe;
  logic [15:0] rsp_rdata;
  logic [17:0] ad_out;
  logic        req_ready_z, rsp_valid_z, rsp_last_z, ad_oe_z, nadv_z, nwe_z, noe_z;
  logic [15:0] rsp_rdata_z;
  logic [17:0] ad_out_z;
  logic        mon_en = 1'b0;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  fsmc_master u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef FSMC_MASTER_BURST_EN
    .req_len(req_len),
`endif
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_last(rsp_last),
    .ad_out(ad_out), .ad_oe(ad_oe), .ad_in(ad_in),
    .nadv(nadv), .nwe(nwe), .noe(noe)
  );

  // every timing parameter zero: each phase must collapse to one cycle
  fsmc_master #(.ADDSET(0), .ADDHLD(0), .DATAST(0), .HOLD(0)) u_zero (
    .clk(clk), .rst(rst), .req_valid(req_valid_z), .req_ready(req_ready_z),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef FSMC_MASTER_BURST_EN
    .req_len(req_len),
`endif
    .rsp_valid(rsp_valid_z), .rsp_rdata(rsp_rdata_z), .rsp_last(rsp_last_z),
    .ad_out(ad_out_z), .ad_oe(ad_oe_z), .ad_in(ad_in),
    .nadv(nadv_z), .nwe(nwe_z), .noe(noe_z)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // expected {nadv,nwe,noe,ad_oe,ad_out} in cycle c after acceptance
  function automatic logic [21:0] exp_bus(input logic wr, input int c,
      input logic [17:0] a, input logic [15:0] d,
      input int s, input int h, input int dt, input int ho);
    int t;
    t = wr ? 0 : 1;
    if (c < 1) return {4'b1110, 18'd0};
    if (c <= s) return {4'b0111, a};
    if (c <= s + h) return {4'b1111, a};
    if (!wr && c == s + h + 1) return {4'b1110, 18'd0};
    if (c <= s + h + t + dt) return wr ? {4'b1011, 2'b00, d} : {4'b1100, 18'd0};
    if (c <= s + h + t + dt + ho) return wr ? {4'b1111, 2'b00, d} : {4'b1110, 18'd0};
    return {4'b1110, 18'd0};
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      n_tests++;
      if ((!nwe && !noe) || (!nadv && !(nwe && noe))) begin
        n_fail++;
        $display("FAIL strobe_overlap t=%0t: nadv=%b nwe=%b noe=%b, required no overlap", $time, nadv, nwe, noe);
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_valid_z = 1'b0; req_write = 1'b0;
    req_addr = 18'd0; req_wdata = 16'h0000; ad_in = 18'h3FFFF;
`ifdef FSMC_MASTER_BURST_EN
    req_len = 11'd1;
`endif
    step(); step();
    n_tests++;
    if ({nadv, nwe, noe, ad_oe, ad_out, req_ready, rsp_valid, rsp_last, rsp_rdata}
        !== {4'b1110, 18'd0, 3'b000, 16'h0000}) begin
      n_fail++;
      $display("FAIL reset_state: got nadv/nwe/noe/oe=%b%b%b%b ad=%h rdy=%b rv=%b rl=%b rd=%h, required 1110 ad=0 rdy=0 rv=0 rl=0 rd=0",
               nadv, nwe, noe, ad_oe, ad_out, req_ready, rsp_valid, rsp_last, rsp_rdata);
    end
    rst = 1'b0;
    #1;
    n_tests++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: got %b, required 1", req_ready);
    end
    mon_en = 1'b1;
  endtask

  task automatic test_read();
    logic [21:0] exp;
    req_write = 1'b0; req_addr = 18'd5; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    for (int c = 1; c <= 24; c++) begin
      ad_in = (c >= 11 && c <= 20) ? 18'h007D0 : 18'h3FFFF;
      exp = exp_bus(1'b0, c, 18'd5, 16'h0000, 5, 4, 10, 3);
      n_tests++;
      if ({nadv, nwe, noe, ad_oe, ad_out} !== exp || rsp_valid !== (c == 24) ||
          rsp_last !== (c == 24) || req_ready !== (c == 24)) begin
        n_fail++;
        $display("FAIL read_bus c=%0d: got %b_%h rv=%b rl=%b rdy=%b, required %b_%h rv=%b",
                 c, {nadv, nwe, noe, ad_oe}, ad_out, rsp_valid, rsp_last, req_ready, exp[21:18], exp[17:0], c == 24);
      end
      if (c < 24) step();
    end
    n_tests++;
    if (rsp_rdata !== 16'h07D0) begin
      n_fail++;
      $display("FAIL read_data: got %h, required 07d0", rsp_rdata);
    end
    ad_in = 18'h3FFFF;
    step(); step();
    n_tests++;
    if (rsp_rdata !== 16'h07D0 || rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL read_data_hold: got rd=%h rv=%b, required 07d0 rv=0", rsp_rdata, rsp_valid);
    end
  endtask

  task automatic test_write();
    logic [21:0] exp;
    req_write = 1'b1; req_addr = 18'h04000; req_wdata = 16'h0001; req_valid = 1'b1;
    n_tests++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL write_ready: got %b, required 1", req_ready);
    end
    step();
    req_valid = 1'b0;
    for (int c = 1; c <= 23; c++) begin
      exp = exp_bus(1'b1, c, 18'h04000, 16'h0001, 5, 4, 10, 3);
      n_tests++;
      if ({nadv, nwe, noe, ad_oe, ad_out} !== exp || rsp_valid !== (c == 23) ||
          rsp_last !== (c == 23) || req_ready !== (c == 23)) begin
        n_fail++;
        $display("FAIL write_bus c=%0d: got %b_%h rv=%b rl=%b rdy=%b, required %b_%h rv=%b",
                 c, {nadv, nwe, noe, ad_oe}, ad_out, rsp_valid, rsp_last, req_ready, exp[21:18], exp[17:0], c == 23);
      end
      if (c == 22) begin
        n_tests++;
        if (rsp_rdata !== 16'h07D0) begin
          n_fail++;
          $display("FAIL write_rdata_hold: got %h, required 07d0", rsp_rdata);
        end
      end
      if (c < 23) step();
    end
    n_tests++;
    if (rsp_rdata !== 16'h0000) begin
      n_fail++;
      $display("FAIL write_rdata_zero: got %h, required 0000", rsp_rdata);
    end
    step();
    n_tests++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL write_idle: got rv=%b rdy=%b, required rv=0 rdy=1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_read_capture();
    req_write = 1'b0; req_addr = 18'h2AAAA; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    for (int c = 1; c <= 24; c++) begin
      ad_in = 18'h30000 | 18'(c);
      if (c < 24) step();
    end
    n_tests++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 16'h0014) begin
      n_fail++;
      $display("FAIL read_capture_edge: got rv=%b rd=%h, required rv=1 rd=0014", rsp_valid, rsp_rdata);
    end
    ad_in = 18'h3FFFF;
  endtask

  task automatic test_back_to_back();
    req_write = 1'b0; req_addr = 18'd7; req_valid = 1'b1;
    step();
    for (int c = 1; c <= 24; c++) begin
      n_tests++;
      if (req_ready !== (c == 24) || rsp_valid !== (c == 24)) begin
        n_fail++;
        $display("FAIL b2b_busy c=%0d: got rdy=%b rv=%b, required %b", c, req_ready, rsp_valid, c == 24);
      end
      step();
    end
    req_valid = 1'b0;
    n_tests++;
    if (nadv !== 1'b0 || ad_out !== 18'd7 || rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_second_accept: got nadv=%b ad=%h rv=%b, required nadv=0 ad=00007 rv=0", nadv, ad_out, rsp_valid);
    end
    for (int c = 26; c <= 48; c++) begin
      step();
      n_tests++;
      if (rsp_valid !== (c == 48)) begin
        n_fail++;
        $display("FAIL b2b_second_rsp c=%0d: got rv=%b, required %b", c, rsp_valid, c == 48);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit bad;
    req_write = 1'b1; req_addr = 18'h00123; req_wdata = 16'hBEEF; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    for (int c = 2; c <= 13; c++) step();
    n_tests++;
    if (nwe !== 1'b0 || ad_out !== 18'h0BEEF) begin
      n_fail++;
      $display("FAIL rstmid_precond: got nwe=%b ad=%h, required nwe=0 ad=0beef", nwe, ad_out);
    end
    rst = 1'b1;
    step();
    n_tests++;
    if ({nadv, nwe, noe, ad_oe, ad_out, rsp_valid, req_ready, rsp_rdata} !== {4'b1110, 18'd0, 2'b00, 16'h0000}) begin
      n_fail++;
      $display("FAIL rstmid_release: got %b ad=%h rv=%b rdy=%b rd=%h, required 1110 ad=0 rv=0 rdy=0 rd=0",
               {nadv, nwe, noe, ad_oe}, ad_out, rsp_valid, req_ready, rsp_rdata);
    end
    rst = 1'b0;
    #1;
    n_tests++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_ready: got %b, required 1", req_ready);
    end
    bad = 1'b0;
    for (int c = 0; c < 30; c++) begin
      step();
      if (rsp_valid !== 1'b0 || {nadv, nwe, noe, ad_oe} !== 4'b1110) bad = 1'b1;
    end
    n_tests++;
    if (bad) begin
      n_fail++;
      $display("FAIL rstmid_quiet: got activity after abort, required idle bus and no rsp_valid");
    end
  endtask

  task automatic test_zero_params();
    logic [21:0] exp;
    req_write = 1'b1; req_addr = 18'h00155; req_wdata = 16'hA5A5; req_valid_z = 1'b1;
    step();
    req_valid_z = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      exp = exp_bus(1'b1, c, 18'h00155, 16'hA5A5, 1, 1, 1, 1);
      n_tests++;
      if ({nadv_z, nwe_z, noe_z, ad_oe_z, ad_out_z} !== exp || rsp_valid_z !== (c == 5) ||
          rsp_last_z !== (c == 5) || req_ready_z !== (c == 5)) begin
        n_fail++;
        $display("FAIL zero_write c=%0d: got %b_%h rv=%b rdy=%b, required %b_%h rv=%b",
                 c, {nadv_z, nwe_z, noe_z, ad_oe_z}, ad_out_z, rsp_valid_z, req_ready_z, exp[21:18], exp[17:0], c == 5);
      end
      if (c < 5) step();
    end
    req_write = 1'b0; req_addr = 18'h00099; ad_in = 18'h20BEE; req_valid_z = 1'b1;
    step();
    req_valid_z = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      exp = exp_bus(1'b0, c, 18'h00099, 16'h0000, 1, 1, 1, 1);
      n_tests++;
      if ({nadv_z, nwe_z, noe_z, ad_oe_z, ad_out_z} !== exp || rsp_valid_z !== (c == 6)) begin
        n_fail++;
        $display("FAIL zero_read c=%0d: got %b_%h rv=%b, required %b_%h rv=%b",
                 c, {nadv_z, nwe_z, noe_z, ad_oe_z}, ad_out_z, rsp_valid_z, exp[21:18], exp[17:0], c == 6);
      end
      if (c < 6) step();
    end
    n_tests++;
    if (rsp_rdata_z !== 16'h0BEE) begin
      n_fail++;
      $display("FAIL zero_read_data: got %h, required 0bee", rsp_rdata_z);
    end
    ad_in = 18'h3FFFF;
  endtask

`ifdef FSMC_MASTER_BURST_EN
  task automatic test_burst_wrap();
    req_write = 1'b0; req_addr = 18'h3FFFF; req_len = 11'd2; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    for (int c = 1; c <= 47; c++) begin
      if (c == 1 || c == 24) begin
        n_tests++;
        if (nadv !== 1'b0 || ad_out !== ((c == 1) ? 18'h3FFFF : 18'h00000)) begin
          n_fail++;
          $display("FAIL burst_wrap_addr c=%0d: got nadv=%b ad=%h", c, nadv, ad_out);
        end
      end
      n_tests++;
      if (rsp_valid !== (c == 24 || c == 47) || rsp_last !== (c == 47) || req_ready !== (c == 47)) begin
        n_fail++;
        $display("FAIL burst_wrap_rsp c=%0d: got rv=%b rl=%b rdy=%b", c, rsp_valid, rsp_last, req_ready);
      end
      if (c < 47) step();
    end
    req_len = 11'd1;
  endtask

  task automatic test_burst_1024();
    int n_rsp;
    n_rsp = 0;
    req_write = 1'b0; req_addr = 18'd0; req_len = 11'd1024; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    for (int c = 1; c <= 23553; c++) begin
      if ((c - 1) % 23 == 0 && (c - 1) / 23 < 1024) begin
        n_tests++;
        if (nadv !== 1'b0 || ad_out !== 18'((c - 1) / 23)) begin
          n_fail++;
          $display("FAIL burst1024_addr word=%0d: got nadv=%b ad=%h, required nadv=0 ad=%h", (c - 1) / 23, nadv, ad_out, 18'((c - 1) / 23));
        end
      end
      if (rsp_valid === 1'b1) begin
        n_rsp++;
        n_tests++;
        if (rsp_last !== (n_rsp == 1024)) begin
          n_fail++;
          $display("FAIL burst1024_last word=%0d: got rl=%b, required %b", n_rsp - 1, rsp_last, n_rsp == 1024);
        end
      end
      if (c < 23553) step();
    end
    n_tests++;
    if (n_rsp != 1024 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL burst1024_count: got %0d pulses rdy=%b, required 1024 rdy=1", n_rsp, req_ready);
    end
    req_len = 11'd1;
  endtask
`endif

  initial begin
    test_reset();
    test_read();
    test_write();
    test_read_capture();
    test_back_to_back();
    test_reset_mid();
    test_zero_params();
`ifdef FSMC_MASTER_BURST_EN
    test_burst_wrap();
    test_burst_1024();
`endif
    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fsmc_master.md
FSMC_MASTER -- requirements
Module: fsmc_master

Interface
REQ-001 The block SHALL have parameter ADDSET, default 5, giving the number of clk cycles NADV is held low with the address driven.
REQ-002 The block SHALL have parameter ADDHLD, default 4, giving the number of clk cycles the address is held after NADV rises.
REQ-003 The block SHALL have parameter DATAST, default 10, giving the number of clk cycles NWE/NOE is held low.
REQ-004 The block SHALL have parameter HOLD, default 3, giving the number of clk cycles the write data and bus drive are held after the strobe rises.
REQ-005 Port clk  input  1  is the single clock; all logic SHALL be on its rising edge.
REQ-006 Port rst  input  1  SHALL be the synchronous, active-high reset.
REQ-007 Port req_valid  input  1  SHALL indicate that a transaction request is presented.
REQ-008 Port req_ready  output  1  SHALL indicate that the block accepts a request this cycle.
REQ-009 Port req_write  input  1  SHALL select the cycle type: 1 = write, 0 = read.
REQ-010 Port req_addr  input  18  SHALL carry the bus address.
REQ-011 Port req_wdata  input  16  SHALL carry the write data.
REQ-012 Port rsp_valid  output  1  SHALL pulse for one cycle per completed word.
REQ-013 Port rsp_rdata  output  16  SHALL carry the read data, valid while rsp_valid is high.
REQ-014 Port rsp_last  output  1  SHALL mark the final word of a request.
REQ-015 Port ad_out  output  18  SHALL carry the address/data value driven onto AD.
REQ-016 Port ad_oe  output  1  SHALL enable the AD drive; 0 releases the bus to high-Z.
REQ-017 Port ad_in  input  18  SHALL carry the sampled AD bus.
REQ-018 Ports nadv, nwe, noe  output  1 each  SHALL be the active-low bus strobes.

Function
REQ-019 The FSM SHALL have states IDLE, ADDR, AHLD, TURN, DATA, HOLD.
REQ-020 req_ready SHALL be 1 only in IDLE, and a request SHALL be accepted on req_valid && req_ready; the request fields SHALL be latched on acceptance.
REQ-021 ADDR SHALL last ADDSET cycles with nadv=0, ad_oe=1 and ad_out={addr}.
REQ-022 AHLD SHALL last ADDHLD cycles with nadv=1, ad_oe=1 and the address held.
REQ-023 A read SHALL pass through TURN for 1 cycle with ad_oe=0 before DATA; a write SHALL skip TURN.
REQ-024 DATA SHALL last DATAST cycles; a write SHALL drive nwe=0, ad_oe=1 and ad_out={2'b0,wdata}; a read SHALL drive noe=0 with ad_oe=0.
REQ-025 A read SHALL register ad_in[15:0] on the last DATA cycle.
REQ-026 HOLD SHALL last HOLD cycles with both strobes high; a write SHALL keep ad_oe=1 and the data; a read SHALL keep ad_oe=0.
REQ-027 rsp_valid SHALL assert in the cycle after the last HOLD cycle, concurrent with the return to IDLE.
REQ-028 Word latency from acceptance to rsp_valid SHALL be ADDSET+ADDHLD+DATAST+HOLD+1 cycles for a write and that value +1 for a read.
REQ-029 Any timing parameter of 0 SHALL be treated as 1.
REQ-030 nwe and noe SHALL never be low simultaneously, and nadv SHALL never be low while either strobe is low.
REQ-031 req_valid asserted while busy SHALL be ignored, with no queueing.
REQ-032 rsp_rdata SHALL hold its last value until the next read completes; after a write, rsp_rdata SHALL be 0.

Reset
REQ-033 While rst=1, the block SHALL enter IDLE with nadv=nwe=noe=1, ad_oe=0, ad_out=0, req_ready=0, rsp_valid=0, rsp_last=0 and rsp_rdata=0; req_ready SHALL be 1 in the first cycle after rst falls.
REQ-034 Reset asserted mid-transaction SHALL release the bus and deassert all strobes at the next edge, the aborted word SHALL produce no rsp_valid, and no partial state SHALL survive.

Configuration
REQ-035 With FSMC_MASTER_BURST_EN defined, the block SHALL have port req_len (input, 11 bits, word count, 0 treated as 1, max 1024).
REQ-036 With FSMC_MASTER_BURST_EN defined, the block SHALL run req_len full word cycles at req_addr+i, with the address wrapping modulo 2^18.
REQ-037 With FSMC_MASTER_BURST_EN defined, each word cycle SHALL produce an rsp_valid pulse, rsp_last SHALL be high only on the final word, and req_ready SHALL stay 0 until the burst ends.
REQ-038 Without FSMC_MASTER_BURST_EN, the block SHALL have no req_len port, each request SHALL be one word, and rsp_last SHALL equal rsp_valid.

Verification
REQ-039 Write at addr 0x4000 with data 0x0001 (default parameters) -> nadv low 5 cycles, address held 4 more, nwe low 10 cycles with ad_out=0x00001, ad_oe low 3 cycles after nwe rises, rsp_valid 23 cycles after acceptance.
REQ-040 Read at addr 5 with ad_in=0x007D0 during DATA -> noe low 10 cycles, ad_oe=0 from TURN on, rsp_rdata=0x07D0 with rsp_valid 24 cycles after acceptance.
REQ-041 req_valid held high during a read -> exactly one transaction, and the second request is accepted only on the first IDLE cycle.
REQ-042 rst=1 in the 4th DATA cycle of a write -> next edge gives nwe=1, ad_oe=0, no rsp_valid, and req_ready=1 one cycle after release.
REQ-043 With FSMC_MASTER_BURST_EN, a burst read with addr 0 and len 1024 -> addresses 0..1023, 1024 rsp_valid pulses, rsp_last on word 1023 only.
REQ-044 With FSMC_MASTER_BURST_EN, addr 0x3FFFF with len 2 -> second address is 0x00000.
